// File: rtl/mux_n_pipe.sv
// N-way select feeding a 2-entry output FIFO; each entry carries {data, sel, err}.
// Handshake: accept on in_valid && in_ready, pop on out_valid && out_ready; in_ready ignores out_ready.
module mux_n_pipe #(
    parameter int               WIDTH       = 32,
    parameter int               NUM_SRC     = 4,
    parameter int               SEL_W       = 2,
    parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_SRC*WIDTH-1:0] src_data,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [SEL_W-1:0]         out_sel,
    output logic                     out_err,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [1:0]               dbg_state_o
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   head_data_q, head_data_d, tail_data_q, tail_data_d;
    logic [SEL_W-1:0]   head_sel_q, head_sel_d, tail_sel_q, tail_sel_d;
    logic               head_err_q, head_err_d, tail_err_q, tail_err_d;
    logic               out_valid_q, out_valid_d;

    logic [WIDTH-1:0]   new_data;
    logic               new_err;
    logic               accept;
    logic               pop;

    // Out-of-range selects fall through to DEFAULT_VAL and flag err.
    always_comb begin
        new_data = DEFAULT_VAL;
        new_err  = 1'b1;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (sel == SEL_W'(k)) begin
                new_data = src_data[k*WIDTH +: WIDTH];
                new_err  = 1'b0;
            end
        end
    end

    assign in_ready = !rst && (state_q != S_FULL);
    assign accept   = in_valid && in_ready;
    assign pop      = out_valid_q && out_ready;

    always_comb begin
        state_d     = state_q;
        head_data_d = head_data_q;
        head_sel_d  = head_sel_q;
        head_err_d  = head_err_q;
        tail_data_d = tail_data_q;
        tail_sel_d  = tail_sel_q;
        tail_err_d  = tail_err_q;
        case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    state_d     = S_ONE;
                    head_data_d = new_data;
                    head_sel_d  = sel;
                    head_err_d  = new_err;
                end
            end
            S_ONE: begin
                if (accept && pop) begin
                    head_data_d = new_data;
                    head_sel_d  = sel;
                    head_err_d  = new_err;
                end else if (accept) begin
                    state_d     = S_FULL;
                    tail_data_d = new_data;
                    tail_sel_d  = sel;
                    tail_err_d  = new_err;
                end else if (pop) begin
                    state_d = S_EMPTY;
                end
            end
            S_FULL: begin
                if (pop) begin
                    state_d     = S_ONE;
                    head_data_d = tail_data_q;
                    head_sel_d  = tail_sel_q;
                    head_err_d  = tail_err_q;
                end
            end
            default: state_d = S_EMPTY;
        endcase
        out_valid_d = (state_d != S_EMPTY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_EMPTY;
            out_valid_q <= 1'b0;
            head_data_q <= '0;
            head_sel_q  <= '0;
            head_err_q  <= 1'b0;
            tail_data_q <= '0;
            tail_sel_q  <= '0;
            tail_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            head_data_q <= head_data_d;
            head_sel_q  <= head_sel_d;
            head_err_q  <= head_err_d;
            tail_data_q <= tail_data_d;
            tail_sel_q  <= tail_sel_d;
            tail_err_q  <= tail_err_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = head_data_q;
    assign out_sel     = head_sel_q;
    assign out_err     = head_err_q;
    assign dbg_state_o = state_q;

endmodule
